// File: rtl/cic_sample_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_uart_pkg
// Description : Shared constants, the transmitter state type and the
//               frame-byte selection helper for the CIC sample UART path.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_uart_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         BYTES_PER_SAMPLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Byte idx of the frame carrying a 24-bit zero-extended sample:
    // sync marker first, then the sample most-significant byte first.
    function automatic logic [7:0] frame_byte(input logic [23:0] word,
                                              input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_sample_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_sample_uart_tx_if
// Description : Sample-capture / UART-status bundle between the CIC output
//               mux (master) and the sample UART transmitter (slave).
//   sample_i      CIC output word, unsigned
//   sample_clk_i  CIC sample clock level; rising edge marks sample_i valid
//   enable_i      capture enable
//   tx_o          UART line, idle high
//   busy_o        frame in progress
//   fifo_level_o  sample FIFO occupancy
//   overflow_o    sticky sample-drop flag
// Revision    : 1.0 - initial release
// ============================================================================
interface cic_sample_uart_tx_if #(
    parameter int DATA_WIDTH = 20,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_clk_i;
    logic                  enable_i;
    logic                  tx_o;
    logic                  busy_o;
    logic [c_LEVEL_W-1:0]  fifo_level_o;
    logic                  overflow_o;

    modport master (
        output sample_i, sample_clk_i, enable_i,
        input  tx_o, busy_o, fifo_level_o, overflow_o
    );

    modport slave (
        input  sample_i, sample_clk_i, enable_i,
        output tx_o, busy_o, fifo_level_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/cic_sample_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. rdata always shows
//               the oldest entry while not empty. A push while full is only
//               accepted when a pop happens in the same cycle.
//   clk_i, rst_i  clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write request and data
//   pop           read request (ignored when empty)
//   rdata         head entry
//   full, empty   occupancy flags
//   level         number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire                          clk_i,
    input  wire                          rst_i,
    input  wire                          push,
    input  wire                          pop,
    input  wire  [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot this push needs.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_level == c_LVL_W'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/cic_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : cic_sample_uart_tx
// Description : Captures each CIC output word on its sample-clock rising
//               edge, queues it, and sends it as a 4-byte 8N1 UART frame
//               (A5, sample[23:16], sample[15:8], sample[7:0]).
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   bus        slave side of cic_sample_uart_tx_if (sample in, line/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module cic_sample_uart_tx #(
    parameter int DATA_WIDTH   = 20,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire                    clk_i,
    input  wire                    rst_i,
    cic_sample_uart_tx_if.slave    bus
);
    import cic_uart_pkg::*;

    localparam int               c_LEVEL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int               c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       c_BYTE_LAST = 2'(BYTES_PER_SAMPLE - 1);

    // ------------------------------------------------------------------
    // Sample-clock edge detect and capture
    // ------------------------------------------------------------------
    logic                  r_sample_clk;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [c_LEVEL_W-1:0]  w_level;
    logic                  r_overflow;

    assign w_push_req = bus.sample_clk_i & ~r_sample_clk & bus.enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sample_clk <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_sample_clk <= bus.sample_clk_i;
            // Only a push that the FIFO really rejects counts as a drop.
            if (w_push_req & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push_req),
        .pop   (w_pop),
        .wdata (bus.sample_i),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    tx_state_t            r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [2:0]           r_bit;
    logic [1:0]           r_byte;
    logic [23:0]          r_word;
    logic                 r_tx;
    logic                 w_baud_end;
    logic [7:0]           w_cur_byte;
    logic [2:0]           w_next_bit;

    assign w_pop      = (r_state == IDLE) & ~w_empty;
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_cur_byte = frame_byte(r_word, r_byte);
    assign w_next_bit = r_bit + 3'd1;

    // r_tx is loaded with the level of the bit that starts next cycle, so
    // the line changes together with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_word  <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_word  <= 24'(w_rdata);
                        r_byte  <= 2'd0;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_tx    <= w_cur_byte[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= w_next_bit;
                            r_tx  <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_byte == c_BYTE_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_byte  <= r_byte + 2'd1;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_o         = r_tx;
    assign bus.busy_o       = (r_state != IDLE);
    assign bus.fifo_level_o = w_level;
    assign bus.overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cic_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_sample_uart_tx
// Description : Self-checking bench for cic_sample_uart_tx. A queue-based
//               line model predicts tx/busy/level/overflow every cycle; a
//               UART decoder recovers bytes for literal frame checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_sample_uart_tx;
    localparam int DW    = 20;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_sample_uart_tx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

    cic_sample_uart_tx #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk   = 1'b0;
    int n_prints = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Line model: a queue of pending samples and a queue of future line
    // levels. A frame is expanded into its 40*CPB line levels when popped.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_q[$];
    bit            m_line[$];
    bit            m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0, m_prev_clk = 1'b0;

    function automatic void load_frame(logic [DW-1:0] s);
        logic [23:0] w;
        logic [7:0]  b;
        bit          v;
        w = 24'(s);
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'hA5 : w[8*(3-k) +: 8];
            for (int i = 0; i < 10; i++) begin
                v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
                for (int r = 0; r < CPB; r++) m_line.push_back(v);
            end
        end
    endfunction

    always @(posedge clk) begin
        bit push, full, pop;
        if (rst) begin
            m_q.delete();
            m_line.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_ovf = 1'b0; m_prev_clk = 1'b0;
        end else begin
            push       = bus_if.sample_clk_i && !m_prev_clk && bus_if.enable_i;
            m_prev_clk = bus_if.sample_clk_i;
            full       = (m_q.size() == DEPTH);
            pop        = !m_busy && (m_q.size() > 0);
            if (pop) load_frame(m_q.pop_front());
            if (push) begin
                if (!full || pop) m_q.push_back(bus_if.sample_i);
                else              m_ovf = 1'b1;
            end
            if (m_line.size() > 0) begin
                m_tx   = m_line.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            n_vec++;
            if (bus_if.tx_o !== m_tx || bus_if.busy_o !== m_busy ||
                bus_if.fifo_level_o !== LW'(m_q.size()) || bus_if.overflow_o !== m_ovf) begin
                n_err++;
                if (n_prints < 40) begin
                    n_prints++;
                    $display("FAIL model_cmp cyc=%0d: got tx=%b busy=%b level=%0d ovf=%b, expected tx=%b busy=%b level=%0d ovf=%b",
                             cyc, bus_if.tx_o, bus_if.busy_o, bus_if.fifo_level_o, bus_if.overflow_o,
                             m_tx, m_busy, m_q.size(), m_ovf);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // UART decoder: mid-bit sampling, abandoned whenever busy is low.
    // ------------------------------------------------------------------
    logic [7:0] rx_q[$];
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_prev = 1'b1;

    always @(negedge clk) begin
        if (bus_if.busy_o !== 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (rx_prev === 1'b1 && bus_if.tx_o === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB && rx_cnt < 9*CPB && (rx_cnt % CPB) == CPB/2)
                rx_byte[rx_cnt/CPB - 1] = bus_if.tx_o;
            if (rx_cnt == 9*CPB + CPB/2) begin
                rx_q.push_back(rx_byte);
                rx_busy = 1'b0;
            end
        end
        rx_prev = bus_if.tx_o;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int rx_at(int i);
        return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
    endfunction

    task automatic check_frame(input string name, input int base, input logic [23:0] w);
        check({name, "_b0"}, rx_at(base),     32'hA5);
        check({name, "_b1"}, rx_at(base + 1), int'(w[23:16]));
        check({name, "_b2"}, rx_at(base + 2), int'(w[15:8]));
        check({name, "_b3"}, rx_at(base + 3), int'(w[7:0]));
    endtask

    // Called on a negedge: edge during this cycle, low the next cycle.
    task automatic send_edge(input logic [DW-1:0] s);
        bus_if.sample_i     = s;
        bus_if.sample_clk_i = 1'b1;
        @(negedge clk);
        bus_if.sample_clk_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((bus_if.busy_o !== 1'b0 || bus_if.fifo_level_o != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: drain timeout, got busy after %0d cycles, expected idle", name, n);
        end
        repeat (2) @(negedge clk);
    endtask

    logic [23:0] ov[6] = '{24'h00001, 24'h12345, 24'hFEDCB, 24'h0F0F0, 24'hA5A5A, 24'h77777};

    initial begin
        int c, n, mx;
        bus_if.sample_i     = '0;
        bus_if.sample_clk_i = 1'b0;
        bus_if.enable_i     = 1'b1;
        rst                 = 1'b1;

        // Reset and idle line
        repeat (3) @(negedge clk);
        check("rst_tx",    int'(bus_if.tx_o),         1);
        check("rst_busy",  int'(bus_if.busy_o),       0);
        check("rst_level", int'(bus_if.fifo_level_o), 0);
        check("rst_ovf",   int'(bus_if.overflow_o),   0);
        rst = 1'b0;
        chk = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_tx", int'(bus_if.tx_o), 1);

        // Single sample
        rx_q.delete();
        c = cyc;
        send_edge(20'hABCDE);
        n = 0;
        while (bus_if.tx_o !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("start_latency", cyc - c, 2);
        n = 0;
        while (bus_if.busy_o === 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("busy_len", n, 160);
        wait_drain("single", 400);
        check("single_nbytes", rx_q.size(), 4);
        check("single_b0", rx_at(0), 32'hA5);
        check("single_b1", rx_at(1), 32'h0A);
        check("single_b2", rx_at(2), 32'hBC);
        check("single_b3", rx_at(3), 32'hDE);

        // Disabled capture ignores edges
        bus_if.enable_i = 1'b0;
        send_edge(20'h33333);
        check("disabled_level", int'(bus_if.fifo_level_o), 0);
        check("disabled_busy",  int'(bus_if.busy_o),       0);
        bus_if.enable_i = 1'b1;

        // Level-held sample clock captures one sample
        rx_q.delete();
        mx = 0;
        bus_if.sample_i     = 20'h5A5A5;
        bus_if.sample_clk_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (int'(bus_if.fifo_level_o) > mx) mx = int'(bus_if.fifo_level_o);
        end
        bus_if.sample_clk_i = 1'b0;
        check("held_peak_level", mx, 1);
        wait_drain("held", 400);
        check("held_nbytes", rx_q.size(), 4);
        check_frame("held", 0, 24'h5A5A5);

        // Overflow: 6 edges two cycles apart during one frame
        rx_q.delete();
        for (int k = 0; k < 6; k++) send_edge(ov[k][DW-1:0]);
        check("ovf_level", int'(bus_if.fifo_level_o), 4);
        check("ovf_flag",  int'(bus_if.overflow_o),   1);
        wait_drain("ovf", 1200);
        check("ovf_nbytes", rx_q.size(), 20);
        for (int f = 0; f < 5; f++) check_frame("ovf_frame", 4*f, ov[f]);
        check("ovf_sticky", int'(bus_if.overflow_o), 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovf_cleared", int'(bus_if.overflow_o), 0);

        // Full FIFO, push lands on the IDLE pop cycle
        rx_q.delete();
        c = cyc;
        for (int k = 0; k < 5; k++) send_edge(ov[k][DW-1:0]);
        wait_until(c + 162);
        bus_if.sample_i     = 20'hC0FFE;
        bus_if.sample_clk_i = 1'b1;
        @(negedge clk);
        bus_if.sample_clk_i = 1'b0;
        check("coll_level", int'(bus_if.fifo_level_o), 4);
        check("coll_ovf",   int'(bus_if.overflow_o),   0);
        wait_drain("coll", 1300);
        check("coll_nbytes", rx_q.size(), 24);
        check_frame("coll_last", 20, 24'hC0FFE);

        // Reset during byte 2 data bits
        rx_q.delete();
        c = cyc;
        send_edge(20'h13579);
        send_edge(20'h2468A);
        wait_until(c + 95);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx",    int'(bus_if.tx_o),         1);
        check("midrst_busy",  int'(bus_if.busy_o),       0);
        check("midrst_level", int'(bus_if.fifo_level_o), 0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        send_edge(20'h0BEEF);
        wait_drain("post_rst", 400);
        check("post_rst_nbytes", rx_q.size(), 4);
        check("post_rst_b0", rx_at(0), 32'hA5);
        check("post_rst_b1", rx_at(1), 32'h00);
        check("post_rst_b2", rx_at(2), 32'hBE);
        check("post_rst_b3", rx_at(3), 32'hEF);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cic_sample_uart_tx.md
# cic_sample_uart_tx

Downstream stage of the CIC decimators: captures each decimated output word on its sample-clock rising edge, buffers it in a small FIFO, and transmits it off-chip as a framed 8N1 UART byte stream on one pin. It sits between the CIC output mux (data word plus `cic_clk_o`) and a spare output pad. It gives a bench or logic analyser a full-resolution sample stream without the 8-bit debug-bus slicing.

## Interface
- `DATA_WIDTH`, 20: width of captured sample, ≤24.
- `FIFO_DEPTH`, 4: sample FIFO entries, power of two, ≥2.
- `CLKS_PER_BIT`, 4: clk cycles per UART bit, ≥1.

- `clk_i`  in  1  system clock. One clock domain.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `sample_i`  in  DATA_WIDTH  CIC output word, unsigned.
- `sample_clk_i`  in  1  CIC output sample clock (level); a rising edge marks `sample_i` valid.
- `enable_i`  in  1  capture enable; when 0, edges are ignored. An in-flight frame still completes.
- `tx_o`  out  1  UART line, idle high, registered.
- `busy_o`  out  1  high while a frame is being transmitted.
- `fifo_level_o`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `overflow_o`  out  1  sticky: a sample was dropped because the FIFO was full.

## Operation
- **Edge detect:** `sample_clk_q` is registered. A push request is `sample_clk_i & ~sample_clk_q & enable_i`. `sample_i` is sampled in that same cycle.
- **FIFO:** synchronous, first-word fall-through.
  - Push when full and no pop in that cycle: drop the new sample and set `overflow_o`. Existing contents are preserved.
  - Push and pop in the same cycle while full: accept both; level is unchanged and `overflow_o` is not set.
  - Push and pop in the same cycle while empty: cannot occur, because pop requires non-empty.
- **Frame:** each sample is 4 bytes, sent in this order:
  - byte 0: `SYNC_BYTE` 0xA5
  - byte 1: zero-extended bits [23:16]
  - byte 2: bits [15:8]
  - byte 3: bits [7:0]
  - The sample is zero-extended to 24 bits.
- **Byte format:** start bit (0), 8 data bits LSB first, stop bit (1).
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop into the shift word, set byte index to 0, and go to START.
  - START: `tx_o`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx_o`=current bit for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `tx_o`=1 for CLKS_PER_BIT cycles. Then, if byte index is 3, go to IDLE; else increment the byte index and go to START.
- `busy_o` = (state != IDLE).
- **Counters:**
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps on every bit boundary.
  - The bit counter is 3 bits; the byte counter is 2 bits.
- `enable_i` deassertion does not flush the FIFO. Queued samples drain.

## Timing
- **Reset values (cycle after `rst_i` is sampled high):**
  - `tx_o`=1, `busy_o`=0, `fifo_level_o`=0, `overflow_o`=0
  - FSM in IDLE, `sample_clk_q`=0, FIFO emptied.
- **Reset mid-frame:** the frame is aborted and `tx_o` returns high on the next cycle. A truncated byte on the line is accepted.
- **Edge detect:** a `sample_clk_i` rising edge in cycle N is written into the FIFO at the end of cycle N. `fifo_level_o` increments in cycle N+1.
- **Frame start:** FIFO non-empty in IDLE at cycle M means pop at cycle M and `tx_o`=0 from cycle M+1.
- **Frame length:** 40·CLKS_PER_BIT cycles, followed by at least 1 IDLE cycle before the next start bit. The back-to-back sample period is 40·CLKS_PER_BIT+1 cycles.
- **Throughput:** the sustained sample rate must not exceed clk/(40·CLKS_PER_BIT+1); otherwise overflow occurs, which is the intended behaviour.
- **Overflow:** `overflow_o` rises in the cycle after the dropped push and stays high until `rst_i`.

## Structure
- Package `cic_uart_pkg` holds:
  - `SYNC_BYTE` (8'hA5)
  - `BYTES_PER_SAMPLE` (4)
  - `tx_state_t` enum {IDLE, START, DATA, STOP}
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports push, pop, wdata, rdata, full, empty, level). It is reusable for other sample paths.
- Top-level instantiation goes alongside the CIC instances, fed by the selected CIC data/clock pair.

## Test plan
- **Reset, idle line:** hold `rst_i` 3 cycles -> `tx_o`=1, `busy_o`=0, `fifo_level_o`=0, `overflow_o`=0. `tx_o` stays 1 with no sample edges.
- **Single sample:** CLKS_PER_BIT=4, `sample_i`=20'hABCDE with one rising edge -> `tx_o` low 2 cycles after the edge. Decoded bytes are A5, 0A, BC, DE. `busy_o` is high for 160 cycles.
- **Level-held clock:** hold `sample_clk_i` high for 50 cycles -> exactly one sample is captured (`fifo_level_o` peaks at 1).
- **Overflow:** 6 edges 2 cycles apart during one frame with FIFO_DEPTH=4 ->
  - the first is popped immediately and the next 4 fill the FIFO;
  - the 6th is dropped and `overflow_o`=1;
  - 5 frames are sent, in order.
- **Full push/pop collision:** FIFO full, push aligned with the IDLE pop cycle -> push accepted, level stays 4, `overflow_o` stays 0.
- **Reset mid-frame:** assert `rst_i` during the DATA state of byte 2 -> `tx_o`=1 next cycle and FIFO empty. A new sample then produces a clean complete frame.
